// File: rtl/data_array_nway_p.sv
// data_array_nway_p: N-way, byte-masked, flop-based data array for the pipelined cache.
// All ways of one set are read in parallel into a registered output. A write landing in the
// same cycle as a read of that set is forwarded. While the output is held (no read), later
// writes to the held set are merged into the output, so a stalled stage never sees stale bytes.
`timescale 1ns/1ps

module data_array_nway_p #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned s_way    = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        read,
    input  logic [s_index-1:0]                          rindex,
    input  logic [(1 << s_offset)-1:0]                  write_en,
    input  logic [s_index-1:0]                          windex,
    input  logic [((s_way > 0) ? s_way : 1)-1:0]        wway,
    input  logic [8*(1 << s_offset)-1:0]                datain,
    output logic [(1 << s_way)*8*(1 << s_offset)-1:0]   dataout,
    output logic                                        dataout_valid
);

    localparam int unsigned s_mask   = 1 << s_offset;
    localparam int unsigned s_line   = 8 * s_mask;
    localparam int unsigned num_sets = 1 << s_index;
    localparam int unsigned num_ways = 1 << s_way;

    // Storage is plain flops so the whole array can be cleared synchronously.
    logic [s_line-1:0]          r_mem [num_sets][num_ways];
    logic [num_ways*s_line-1:0] r_dataout;
    logic                       r_valid;
    logic [s_index-1:0]         r_held_index;

    logic [num_ways*s_line-1:0] w_dataout_next;
    logic [s_line-1:0]          w_bitmask;
    logic [num_ways-1:0]        w_wway_sel;
    logic                       w_hold_hit;

    // Replace only the masked bits of a line.
    function automatic logic [s_line-1:0] merge_bytes(input logic [s_line-1:0] old_line,
                                                      input logic [s_line-1:0] new_line,
                                                      input logic [s_line-1:0] mask);
        return (old_line & ~mask) | (new_line & mask);
    endfunction

    // One-hot write-way select; a single-way array ignores wway entirely.
    if (s_way == 0) begin : g_one_way
        logic w_unused_wway;
        assign w_unused_wway = ^wway;
        assign w_wway_sel    = 1'b1;
    end else begin : g_multi_way
        assign w_wway_sel = {{(num_ways-1){1'b0}}, 1'b1} << wway;
    end

    // Expand the byte write enables into a per-bit mask.
    always_comb begin
        w_bitmask = '0;
        for (int unsigned i = 0; i < s_mask; i++) begin
            w_bitmask[8*i +: 8] = {8{write_en[i]}};
        end
    end

    // A write to the set currently held in a valid output register.
    assign w_hold_hit = r_valid && (windex == r_held_index);

    // Array update: synchronous clear, otherwise masked write into (windex, wway).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < num_sets; s++) begin
                for (int unsigned w = 0; w < num_ways; w++) begin
                    r_mem[s][w] <= '0;
                end
            end
        end else begin
            for (int unsigned s = 0; s < num_sets; s++) begin
                for (int unsigned w = 0; w < num_ways; w++) begin
                    if ((windex == s_index'(s)) && w_wway_sel[w]) begin
                        r_mem[s][w] <= merge_bytes(r_mem[s][w], datain, w_bitmask);
                    end
                end
            end
        end
    end

    // Next output: capture with forwarding on read, else coherent merge into the held line.
    always_comb begin
        w_dataout_next = r_dataout;
        for (int unsigned w = 0; w < num_ways; w++) begin
            if (read) begin
                if ((windex == rindex) && w_wway_sel[w]) begin
                    w_dataout_next[w*s_line +: s_line] =
                        merge_bytes(r_mem[rindex][w], datain, w_bitmask);
                end else begin
                    w_dataout_next[w*s_line +: s_line] = r_mem[rindex][w];
                end
            end else if (w_hold_hit && w_wway_sel[w]) begin
                w_dataout_next[w*s_line +: s_line] =
                    merge_bytes(r_dataout[w*s_line +: s_line], datain, w_bitmask);
            end
        end
    end

    // Output register, valid flag and held index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dataout    <= '0;
            r_valid      <= 1'b0;
            r_held_index <= '0;
        end else begin
            r_dataout <= w_dataout_next;
            if (read) begin
                r_valid      <= 1'b1;
                r_held_index <= rindex;
            end
        end
    end

    assign dataout       = r_dataout;
    assign dataout_valid = r_valid;

endmodule

// File: tb/tb_data_array_nway_p.sv
// tb_data_array_nway_p: directed checks on a 2-way array plus randomized scoreboards on
// 1-, 2- and 4-way arrays, each against a byte-level reference model.
`timescale 1ns/1ps

module tb_data_array_nway_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int rand_done = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [7:0] b);
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[8*i +: 8] = b;
        return v;
    endfunction

    // ---------------- directed instance (2 ways) ----------------
    logic         d_rst, d_read, d_wway, d_dv;
    logic [2:0]   d_rindex, d_windex;
    logic [31:0]  d_we;
    logic [255:0] d_din;
    logic [511:0] d_dout;

    data_array_nway_p #(.s_offset(5), .s_index(3), .s_way(1)) u_dir (
        .clk          (clk),
        .rst          (d_rst),
        .read         (d_read),
        .rindex       (d_rindex),
        .write_en     (d_we),
        .windex       (d_windex),
        .wway         (d_wway),
        .datain       (d_din),
        .dataout      (d_dout),
        .dataout_valid(d_dv)
    );

    task automatic drv(input logic rd, input logic [2:0] ri, input logic [31:0] we,
                       input logic [2:0] wi, input logic ww, input logic [255:0] din);
        d_read   = rd;
        d_rindex = ri;
        d_we     = we;
        d_windex = wi;
        d_wway   = ww;
        d_din    = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- randomized instances (1, 2, 4 ways) ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int NW = 1 << g;
        localparam int WW = (g > 0) ? g : 1;

        logic            rst, rd, dv;
        logic [2:0]      ri, wi;
        logic [31:0]     we;
        logic [WW-1:0]   ww;
        logic [255:0]    din;
        logic [NW*256-1:0] dout;

        logic [7:0] mem  [8][NW][32];
        logic [7:0] mout [NW][32];
        bit         mvalid;
        int         mheld;

        data_array_nway_p #(.s_offset(5), .s_index(3), .s_way(g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .read         (rd),
            .rindex       (ri),
            .write_en     (we),
            .windex       (wi),
            .wway         (ww),
            .datain       (din),
            .dataout      (dout),
            .dataout_valid(dv)
        );

        initial begin
            int wsel;
            logic [255:0] e;
            for (int c = 0; c < 10000; c++) begin
                @(negedge clk);
                rst = (c < 2) ? 1'b1 : ($urandom_range(0, 199) == 0);
                rd  = 1'($urandom_range(0, 1));
                ri  = 3'($urandom);
                wi  = ($urandom_range(0, 2) == 0) ? ri : 3'($urandom);
                ww  = (NW > 1) ? WW'($urandom_range(0, NW - 1)) : '0;
                case ($urandom_range(0, 3))
                    0:       we = '0;
                    1:       we = $urandom;
                    2:       we = 32'd1 << $urandom_range(0, 31);
                    default: we = '1;
                endcase
                for (int k = 0; k < 8; k++) din[32*k +: 32] = $urandom;

                @(posedge clk);
                wsel = (NW > 1) ? int'(ww) : 0;
                if (rst) begin
                    for (int s = 0; s < 8; s++)
                        for (int w = 0; w < NW; w++)
                            for (int i = 0; i < 32; i++) mem[s][w][i] = 8'h00;
                    for (int w = 0; w < NW; w++)
                        for (int i = 0; i < 32; i++) mout[w][i] = 8'h00;
                    mvalid = 0;
                    mheld  = 0;
                end else begin
                    for (int i = 0; i < 32; i++)
                        if (we[i]) mem[wi][wsel][i] = din[8*i +: 8];
                    if (rd) begin
                        // Capturing after the write is applied is exactly forwarding.
                        for (int w = 0; w < NW; w++)
                            for (int i = 0; i < 32; i++) mout[w][i] = mem[ri][w][i];
                        mvalid = 1;
                        mheld  = int'(ri);
                    end else if (mvalid && int'(wi) == mheld) begin
                        for (int i = 0; i < 32; i++)
                            if (we[i]) mout[wsel][i] = din[8*i +: 8];
                    end
                end
                #1;
                for (int w = 0; w < NW; w++) begin
                    for (int i = 0; i < 32; i++) e[8*i +: 8] = mout[w][i];
                    check($sformatf("rand_s%0d_c%0d_way%0d", g, c, w), dout[w*256 +: 256], e);
                end
                check($sformatf("rand_s%0d_c%0d_valid", g, c), 256'(dv), 256'(mvalid));
            end
            rand_done++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [255:0] e, e2, pat;

        d_rst = 1'b1;
        drv(1'b0, 3'd0, '0, 3'd0, 1'b0, '0);
        tick();
        tick();
        check("reset_valid", 256'(d_dv), 256'(1'b0));
        check("reset_way0", d_dout[255:0], '0);
        check("reset_way1", d_dout[511:256], '0);
        d_rst = 1'b0;

        // Reset clears a written line.
        drv(1'b0, 3'd0, '1, 3'd2, 1'b1, fill(8'hAA));
        tick();
        drv(1'b1, 3'd2, '0, 3'd0, 1'b0, '0);
        tick();
        check("preclear_way1", d_dout[511:256], fill(8'hAA));
        check("preclear_way0", d_dout[255:0], '0);
        d_rst = 1'b1;
        drv(1'b1, 3'd2, '1, 3'd2, 1'b1, fill(8'h55));
        tick();
        check("midreset_valid", 256'(d_dv), 256'(1'b0));
        check("midreset_way1", d_dout[511:256], '0);
        d_rst = 1'b0;

        // With no valid capture, a write to the (reset) held index must not touch dataout.
        drv(1'b0, 3'd0, '1, 3'd0, 1'b0, fill(8'h99));
        tick();
        check("invalid_nohold_way0", d_dout[255:0], '0);
        check("invalid_nohold_valid", 256'(d_dv), 256'(1'b0));

        drv(1'b1, 3'd2, '0, 3'd0, 1'b0, '0);
        tick();
        check("cleared_way0", d_dout[255:0], '0);
        check("cleared_way1", d_dout[511:256], '0);
        check("cleared_valid", 256'(d_dv), 256'(1'b1));

        // Masked write then read.
        for (int i = 0; i < 32; i++) pat[8*i +: 8] = 8'(i);
        drv(1'b0, 3'd0, 32'h0000_FFFF, 3'd5, 1'b0, pat);
        tick();
        drv(1'b1, 3'd5, '0, 3'd0, 1'b0, '0);
        tick();
        check("masked_way0", d_dout[255:0], {128'b0, pat[127:0]});
        check("masked_way1", d_dout[511:256], '0);

        // Same-cycle forwarding.
        drv(1'b0, 3'd0, '1, 3'd3, 1'b1, fill(8'h11));
        tick();
        e = fill(8'hEE);
        e[7:0] = 8'h5A;
        drv(1'b1, 3'd3, 32'h1, 3'd3, 1'b1, e);
        tick();
        e = fill(8'h11);
        e[7:0] = 8'h5A;
        check("fwd_way1", d_dout[511:256], e);
        check("fwd_way0", d_dout[255:0], '0);

        // Coherent hold on set 4.
        drv(1'b1, 3'd4, '0, 3'd0, 1'b0, '0);
        tick();
        check("hold_capture_way1", d_dout[511:256], '0);
        drv(1'b0, 3'd0, '0, 3'd4, 1'b1, fill(8'hFF));
        tick();
        check("hold_idle_way1", d_dout[511:256], '0);
        drv(1'b0, 3'd0, 32'h8000_0000, 3'd4, 1'b1, fill(8'hC3));
        tick();
        e = '0;
        e[255:248] = 8'hC3;
        check("hold_update_way1", d_dout[511:256], e);
        check("hold_update_way0", d_dout[255:0], '0);
        check("hold_update_valid", 256'(d_dv), 256'(1'b1));
        drv(1'b0, 3'd0, '1, 3'd6, 1'b1, fill(8'h77));
        tick();
        check("hold_other_set_way1", d_dout[511:256], e);
        drv(1'b0, 3'd0, '1, 3'd7, 1'b0, fill(8'h33));
        tick();
        check("hold_other_set_way0", d_dout[255:0], '0);

        // New read beats a write to the stale held set.
        drv(1'b1, 3'd7, 32'h1, 3'd4, 1'b0, fill(8'hFF));
        tick();
        check("readwins_way0", d_dout[255:0], fill(8'h33));
        check("readwins_way1", d_dout[511:256], '0);
        drv(1'b1, 3'd4, '0, 3'd0, 1'b0, '0);
        tick();
        e2 = '0;
        e2[7:0] = 8'hFF;
        check("reread4_way0", d_dout[255:0], e2);
        check("reread4_way1", d_dout[511:256], e);
        drv(1'b0, 3'd0, '0, 3'd0, 1'b0, '0);

        wait (rand_done == 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_array_nway_p.md
# data_array_nway_p

Multi-way, byte-masked data array for the pipelined cache. It stores `num_ways` lines per set and reads all ways of one set in parallel into a registered output, so the cache's second stage can mux on the hit way. It keeps the same-cycle write-to-read forwarding of the single-way data array. It adds a coherent hold: while the pipeline stalls, the registered output tracks later writes to the line it holds, so a stalled stage never consumes stale bytes.

## Interface
- `s_offset`, default 5: log2 of bytes per line. `s_mask = 2**s_offset`, `s_line = 8*s_mask`.
- `s_index`, default 3: log2 of the set count. `num_sets = 2**s_index`.
- `s_way`, default 1: log2 of the way count. `num_ways = 2**s_way`. `s_way = 0` (one way) must work.

Ports:
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `read`  in  1  capture set `rindex` into the output register at this edge.
- `rindex`  in  s_index  read set.
- `write_en`  in  s_mask  byte write mask. All zeros means no write.
- `windex`  in  s_index  write set.
- `wway`  in  s_way  write way.
- `datain`  in  s_line  write data. Byte i is `[8*i +: 8]`.
- `dataout`  out  num_ways*s_line  registered read data. Way w is `[w*s_line +: s_line]`.
- `dataout_valid`  out  1  `dataout` holds a captured set.

## Operation
Storage and reset:
- `rst` high at an edge:
  - every byte of every way and set becomes 0;
  - `dataout` becomes 0, `dataout_valid` becomes 0, the held index becomes 0;
  - writes and reads in that cycle are ignored.
- Writes commit every non-reset edge, independent of `read`. Only bytes with `write_en[i]=1` in (`windex`, `wway`) change. All other bytes, ways and sets keep their values.

Read capture (`read=1`):
- Each way w, byte i of `dataout` loads the stored byte at `rindex`.
- Forwarding exception: it loads `datain` byte i instead when all of these hold: `write_en[i]=1`, `windex==rindex`, `wway==w`.
- The held index becomes `rindex`. `dataout_valid` becomes 1.

Hold (`read=0`):
- `dataout` keeps its value, except for the coherent-hold update below. The held index and `dataout_valid` are unchanged.
- Coherent-hold update: applies when `dataout_valid=1` and `windex` equals the held index. Then each byte i with `write_en[i]=1` in way `wway` of `dataout` loads `datain` byte i. Other ways and bytes are untouched.
- If `dataout_valid=0`, a write never touches `dataout`.

Simultaneous events:
- A read of set A together with a write to set A: the output shows the new bytes (forwarding).
- A read of set A together with a write to set B: the array is updated and the output is unaffected. A later read of B returns the written bytes.
- A write to the held set in the same cycle as a new `read` of a different set: the new read wins. The old held copy is discarded.
- No read/write port conflict exists. There are no stalls and no backpressure outputs.

Storage must be flip-flop/logic based (no inferred block RAM), because the array needs a synchronous clear.

## Timing
- Read latency is 1 edge. With `read` and `rindex` applied in cycle t, `dataout` is valid after the edge ending cycle t, for use in cycle t+1 (the two-stage read of the cache pipeline).
- Write latency is 1 edge. A write in cycle t is visible to a `read` in cycle t by forwarding, and in the array from cycle t+1.
- `dataout` changes only at edges where `read=1`, `rst=1`, or a coherent-hold write hits.
- Reset mid-operation: a held line and `dataout_valid` are cleared at the reset edge. The first read after reset returns zeros, unless forwarded.
- There is no combinational path from any input to `dataout` or `dataout_valid`.

## Test plan
- Reset clears: write 0xAA to all bytes of (set 2, way 1), assert `rst` for 1 cycle, then read set 2. Required: `dataout` = 0 in both ways, `dataout_valid` = 1 after the read and 0 during reset.
- Masked write then read: write `datain` = byte pattern i in byte i, `write_en` = 0x0000FFFF, to (set 5, way 0), then read set 5 next cycle. Required: way 0 bytes 0-15 = i, bytes 16-31 = 0, way 1 = 0.
- Same-cycle forwarding: set 3 way 1 = 0x11 in all bytes. In one cycle, `read` set 3 and write byte 0 = 0x5A to (set 3, way 1). Required: next cycle way 1 byte 0 = 0x5A, bytes 1-31 = 0x11, way 0 unchanged.
- Coherent hold: read set 4 (all 0), hold `read=0` for 3 cycles, and in cycle 2 write byte 31 = 0xC3 to (set 4, way 1). Required: `dataout` way 1 byte 31 = 0xC3 from the next edge, all else 0. A write to set 6 in cycle 3 leaves `dataout` unchanged.
- Read beats stale hold: hold set 4, then in one cycle `read` set 7 and write byte 0 = 0xFF to (set 4, way 0). Required: `dataout` = set 7 contents, and a later read of set 4 returns 0xFF in way 0 byte 0.
- Randomized scoreboard: 10k cycles of random read/rindex/write_en/windex/wway with `s_way = 0`, 1 and 2, checked against a reference model. Required: zero mismatches.
